id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline register for the five-stage RISC-V pipeline. Latches the decoded control bundle from the Control unit plus operand data and register addresses from the ID stage into the EX stage. Optionally detects load-use hazards and inserts a bubble. Accepts a downstream hold and a branch flush, and drives the stall to the PC and IF/ID registers.

## Interface
- DATA_W, 32: operand and immediate width
- REG_AW, 5: register-address width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- ALUOp_i  in  2  ALU op class from Control
- ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i  in  1 each  control from Control
- RS1data_i, RS2data_i, Imm_i  in  DATA_W  register-file reads and sign-extended immediate
- funct_i  in  10  {funct7, funct3}
- RS1addr_i, RS2addr_i, RDaddr_i  in  REG_AW  ID-stage register addresses
- flush_i  in  1  kill the instruction entering from ID (taken branch)
- hold_i  in  1  downstream not ready; freeze EX contents
- ALUOp_o, ALUSrc_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o  out  2/1  registered control
- RS1data_o, RS2data_o, Imm_o, funct_o, RS1addr_o, RS2addr_o, RDaddr_o  out  as inputs  registered data
- valid_o  out  1  EX slot holds a real instruction
- stall_o  out  1  freeze PC and IF/ID this cycle
- bubble_cnt_o  out  16  count of hazard bubbles inserted

## Operation
- Each rising edge selects one of four actions. Priority runs highest to lowest: hold, flush, bubble, load.
- hold_i=1: every register keeps its value. stall_o=1. flush_i is ignored; the requester keeps it asserted until hold_i drops.
- flush_i=1: load a bubble.
- Hazard (macro on):
  - Condition: MemRead_o=1, valid_o=1, RDaddr_o≠0, and RDaddr_o equals RS1addr_i or RS2addr_i.
  - Response: stall_o=1 and load a bubble. The ID instruction is re-presented next cycle, because upstream is frozen by stall_o.
- Otherwise, load: all *_o fields take the matching *_i values and valid_o=1.
- Bubble:
  - valid_o=0.
  - All control outputs are 0, so RegWrite_o=0, MemRead_o=0 and MemWrite_o=0.
  - All data and address fields are 0 for determinism.
- bubble_cnt_o increments by 1 on each hazard bubble. It does not count flush or hold. It saturates at 16'hFFFF.
- x0 is never a hazard source.

## Timing
- Latency is one cycle from ID inputs to *_o.
- stall_o is combinational from registered EX state, ID addresses and hold_i, valid in the same cycle.
- stall_o = hold_i | hazard.
- A load-use pair costs exactly one bubble.
  - Cycle n: lw in ID.
  - Cycle n+1: lw in EX, user in ID, stall_o=1.
  - Edge n+2: bubble enters EX, lw moves on, and the hazard clears.
  - Edge n+3: user loads.
- When flush and hazard occur together, flush wins. stall_o still follows the hazard for that cycle. bubble_cnt_o does not increment.
- Reset:
  - rst_i=0 clears every output register to 0 immediately, without waiting for a clock.
  - valid_o=0, bubble_cnt_o=0, and stall_o=0 unless hold_i=1.
  - Reset asserted mid-hold or mid-stall overrides both.
- Release is synchronous-safe: the first edge with rst_i=1 performs a normal action.

## Configuration
- HAZARD_DETECT_EN defined: load-use detection, bubble insertion and bubble_cnt_o are built.
- Undefined:
  - No hazard logic; stall_o = hold_i.
  - bubble_cnt_o is constant 0.
  - Flush and hold behave identically to the defined build.
  - Forwarding or software NOPs must cover load-use hazards.

## Test plan
- Async reset: load RS1data_i=32'hDEAD_BEEF with RegWrite_i=1, then pulse rst_i=0 between edges -> all outputs 0 at once; valid_o=0; bubble_cnt_o=0.
- Normal load: R-type with ALUOp_i=00, RegWrite_i=1, RS1data_i=5, RS2data_i=7, RDaddr_i=3 -> next edge shows the same values on *_o; valid_o=1; stall_o=0.
- Load-use (macro on):
  - lw with MemRead_i=1, RDaddr_i=5, then an add with RS1addr_i=5 -> stall_o=1 for exactly one cycle.
  - The following EX slot has valid_o=0 and RegWrite_o=0; bubble_cnt_o=1.
  - The add appears in EX one cycle later with valid_o=1.
- x0 and no-match: lw to RD=0 followed by a use of x0, then lw to RD=6 followed by a use of x7 -> stall_o stays 0.
- Flush: flush_i=1 while a valid sw is in ID -> next edge MemWrite_o=0 and valid_o=0; bubble_cnt_o unchanged.
- Hold:
  - hold_i=1 for 3 cycles with changing inputs and flush_i pulsed in cycle 2 -> outputs frozen and stall_o=1 throughout.
  - After release, the first edge loads the current ID inputs.

Source files
------------

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with hold, flush and optional load-use bubble
// Define HAZARD_DETECT_EN to build load-use detection, bubble insertion and bubble_cnt_o.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        ALUOp_i,
  input  logic              ALUSrc_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [DATA_W-1:0] RS1data_i,
  input  logic [DATA_W-1:0] RS2data_i,
  input  logic [DATA_W-1:0] Imm_i,
  input  logic [9:0]        funct_i,
  input  logic [REG_AW-1:0] RS1addr_i,
  input  logic [REG_AW-1:0] RS2addr_i,
  input  logic [REG_AW-1:0] RDaddr_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic [1:0]        ALUOp_o,
  output logic              ALUSrc_o,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic [DATA_W-1:0] RS1data_o,
  output logic [DATA_W-1:0] RS2data_o,
  output logic [DATA_W-1:0] Imm_o,
  output logic [9:0]        funct_o,
  output logic [REG_AW-1:0] RS1addr_o,
  output logic [REG_AW-1:0] RS2addr_o,
  output logic [REG_AW-1:0] RDaddr_o,
  output logic              valid_o,
  output logic              stall_o,
  output logic [15:0]       bubble_cnt_o
);

  logic [1:0]        alu_op_q,    alu_op_d;
  logic              alu_src_q,   alu_src_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic              mem_read_q,  mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [DATA_W-1:0] rs1_data_q,  rs1_data_d;
  logic [DATA_W-1:0] rs2_data_q,  rs2_data_d;
  logic [DATA_W-1:0] imm_q,       imm_d;
  logic [9:0]        funct_q,     funct_d;
  logic [REG_AW-1:0] rs1_addr_q,  rs1_addr_d;
  logic [REG_AW-1:0] rs2_addr_q,  rs2_addr_d;
  logic [REG_AW-1:0] rd_addr_q,   rd_addr_d;
  logic              valid_q,     valid_d;
  logic              hazard;

`ifdef HAZARD_DETECT_EN
  logic [15:0]       bubble_cnt_q, bubble_cnt_d;

  // x0 is hardwired zero, so a load targeting it can never feed a consumer
  assign hazard = valid_q && mem_read_q && (rd_addr_q != '0) &&
                  ((rd_addr_q == RS1addr_i) || (rd_addr_q == RS2addr_i));

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!hold_i && !flush_i && hazard && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt_o = bubble_cnt_q;
`else
  assign hazard       = 1'b0;
  assign bubble_cnt_o = '0;
`endif

  assign stall_o = hold_i | hazard;

  always_comb begin
    alu_op_q_hold: begin
      alu_op_d     = alu_op_q;
      alu_src_d    = alu_src_q;
      reg_write_d  = reg_write_q;
      mem_to_reg_d = mem_to_reg_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      rs1_data_d   = rs1_data_q;
      rs2_data_d   = rs2_data_q;
      imm_d        = imm_q;
      funct_d      = funct_q;
      rs1_addr_d   = rs1_addr_q;
      rs2_addr_d   = rs2_addr_q;
      rd_addr_d    = rd_addr_q;
      valid_d      = valid_q;
    end
    // hold freezes everything; flush outranks the hazard bubble but both zero the slot
    if (!hold_i) begin
      if (flush_i || hazard) begin
        alu_op_d     = '0;
        alu_src_d    = 1'b0;
        reg_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        rs1_data_d   = '0;
        rs2_data_d   = '0;
        imm_d        = '0;
        funct_d      = '0;
        rs1_addr_d   = '0;
        rs2_addr_d   = '0;
        rd_addr_d    = '0;
        valid_d      = 1'b0;
      end else begin
        alu_op_d     = ALUOp_i;
        alu_src_d    = ALUSrc_i;
        reg_write_d  = RegWrite_i;
        mem_to_reg_d = MemtoReg_i;
        mem_read_d   = MemRead_i;
        mem_write_d  = MemWrite_i;
        rs1_data_d   = RS1data_i;
        rs2_data_d   = RS2data_i;
        imm_d        = Imm_i;
        funct_d      = funct_i;
        rs1_addr_d   = RS1addr_i;
        rs2_addr_d   = RS2addr_i;
        rd_addr_d    = RDaddr_i;
        valid_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      alu_op_q     <= '0;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      funct_q      <= '0;
      rs1_addr_q   <= '0;
      rs2_addr_q   <= '0;
      rd_addr_q    <= '0;
      valid_q      <= 1'b0;
    end else begin
      alu_op_q     <= alu_op_d;
      alu_src_q    <= alu_src_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      funct_q      <= funct_d;
      rs1_addr_q   <= rs1_addr_d;
      rs2_addr_q   <= rs2_addr_d;
      rd_addr_q    <= rd_addr_d;
      valid_q      <= valid_d;
    end
  end

  assign ALUOp_o    = alu_op_q;
  assign ALUSrc_o   = alu_src_q;
  assign RegWrite_o = reg_write_q;
  assign MemtoReg_o = mem_to_reg_q;
  assign MemRead_o  = mem_read_q;
  assign MemWrite_o = mem_write_q;
  assign RS1data_o  = rs1_data_q;
  assign RS2data_o  = rs2_data_q;
  assign Imm_o      = imm_q;
  assign funct_o    = funct_q;
  assign RS1addr_o  = rs1_addr_q;
  assign RS2addr_o  = rs2_addr_q;
  assign RDaddr_o   = rd_addr_q;
  assign valid_o    = valid_q;

endmodule
